// File: rtl/fetch_if.sv
// Instruction-memory handshake between the fetch sequencer (master) and imem (slave).
// One outstanding request at a time; the response strobe returns the word.
interface fetch_if #(
    parameter int XLEN = 32
);
    logic            imem_req;
    logic [XLEN-3:0] imem_addr;
    logic            imem_rvalid;
    logic [31:0]     imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_ctrl.sv
// IF-stage fetch sequencer: owns the fetch PC, issues single-outstanding imem requests,
// buffers the returned word for IF/ID, and applies redirect > response > stall priority.
module fetch_ctrl #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            StallF,
    input  logic            RedirectE,
    input  logic [XLEN-1:0] RedirectPCE,
    fetch_if.master         imem,
    output logic [XLEN-1:0] PCF,
    output logic [XLEN-1:0] PCPlus4F,
    output logic [31:0]     instrF,
    output logic            validF
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_ISSUE,
        S_WAIT,
        S_HOLD,
        S_DRAIN
    } state_t;

    state_t          state_q;
    logic [XLEN-1:0] pc_q;
    logic [31:0]     instr_q;
    logic            valid_q;
    logic [XLEN-1:0] target;

    assign target = RedirectPCE & ~XLEN'(3);

    // A redirect sampled in ISSUE retargets the PC instead of sending a request that
    // would otherwise come back as an unaccounted second response.
    assign imem.imem_req  = rst_n && (state_q == S_ISSUE) && !RedirectE;
    assign imem.imem_addr = pc_q[XLEN-1:2];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_ISSUE;
            pc_q    <= RESET_PC;
            instr_q <= NOP;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_ISSUE: begin
                    if (RedirectE) begin
                        pc_q <= target;
                    end else begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (RedirectE) begin
                        pc_q    <= target;
                        state_q <= imem.imem_rvalid ? S_ISSUE : S_DRAIN;
                    end else if (imem.imem_rvalid) begin
                        instr_q <= imem.imem_rdata;
                        valid_q <= 1'b1;
                        state_q <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (RedirectE) begin
                        valid_q <= 1'b0;
                        pc_q    <= target;
                        state_q <= S_ISSUE;
                    end else if (!StallF) begin
                        valid_q <= 1'b0;
                        pc_q    <= pc_q + XLEN'(4);
                        state_q <= S_ISSUE;
                    end
                end
                S_DRAIN: begin
                    if (RedirectE) begin
                        pc_q <= target;
                    end
                    if (imem.imem_rvalid) begin
                        state_q <= S_ISSUE;
                    end
                end
                default: state_q <= S_ISSUE;
            endcase
        end
    end

    assign PCF      = pc_q;
    assign PCPlus4F = pc_q + XLEN'(4);
    assign instrF   = instr_q;
    assign validF   = valid_q;

endmodule
